load_store_unit: RTL and testbench

//  Sits between the core's memory-access stage and the data side of the unified memory (port B: address/write-data/write-enable in, read-data out).

---
 rtl/mem_pkg.sv | 39 +++
 rtl/load_store_unit_if.sv | 26 ++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/load_store_unit.sv | 100 ++++++++++
 tb/tb_load_store_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, constants and access-check helpers for the load/store unit
package mem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } lsu_state_t;

    localparam logic [15:0] MMIO_HI_DEFAULT = 16'hFFFF;

    // Illegal encodings and misaligned halves/words both end in an error response.
    function automatic logic access_bad(input logic [2:0] funct3, input logic [1:0] lo);
        case (funct3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return lo[0];
            F3_W:        return lo != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] zext_store(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3)
            F3_B, F3_BU: return {24'h0, data[7:0]};
            F3_H, F3_HU: return {16'h0, data[15:0]};
            default:     return data;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and memory port B signals of the load/store unit
interface load_store_unit_if;
    logic        Req;
    logic        IsStore;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic        MemWe;
    logic [31:0] MemReadData;
    logic [31:0] LoadData;
    logic        Ready;
    logic        Busy;
    logic        MisalignExc;

    modport master (
        output Req, IsStore, Funct3, Addr, StoreData, MemReadData,
        input  MemAddr, MemWriteData, MemWe, LoadData, Ready, Busy, MisalignExc
    );

    modport slave (
        input  Req, IsStore, Funct3, Addr, StoreData, MemReadData,
        output MemAddr, MemWriteData, MemWe, LoadData, Ready, Busy, MisalignExc
    );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - load lane extraction with sign/zero extension and sub-word store merge
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] data,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] extracted,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = 8'(word >> {lane, 3'b000});
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        extracted = word;
        case (funct3)
            F3_B:    extracted = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   extracted = {24'h0, byte_sel};
            F3_H:    extracted = {{16{half_sel[15]}}, half_sel};
            F3_HU:   extracted = {16'h0, half_sel};
            default: extracted = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (funct3)
            F3_B, F3_BU: merged[{lane, 3'b000} +: 8] = data[7:0];
            F3_H, F3_HU: merged[{lane[1], 4'b0000} +: 16] = data[15:0];
            default:     merged = data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - turns byte/half/word loads and stores into word-only memory port B traffic
module load_store_unit
    import mem_pkg::*;
#(
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] MMIO_HI      = MMIO_HI_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    localparam logic [7:0] CNT_INIT = 8'(READ_LATENCY - 1);

    lsu_state_t  state, state_next;
    logic [31:0] a_addr, a_data, wbuf, load_q;
    logic [2:0]  a_f3;
    logic        a_store, err;
    logic [7:0]  cnt;
    logic [31:0] load_ext, merged;
    logic        req_bad, req_direct_wr;

    assign req_bad       = access_bad(bus.Funct3, bus.Addr[1:0]);
    // Word stores and all MMIO stores skip the read: MMIO registers must not see a read side effect.
    assign req_direct_wr = bus.IsStore &&
                           (bus.Funct3 == F3_W || bus.Addr[31:16] == MMIO_HI);

    lsu_lane_align u_align (
        .word      (bus.MemReadData),
        .data      (a_data),
        .lane      (a_addr[1:0]),
        .funct3    (a_f3),
        .extracted (load_ext),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            a_addr  <= '0;
            a_data  <= '0;
            a_f3    <= '0;
            a_store <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            wbuf    <= '0;
            load_q  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (bus.Req) begin
                    a_addr  <= bus.Addr;
                    a_data  <= bus.StoreData;
                    a_f3    <= bus.Funct3;
                    a_store <= bus.IsStore;
                    err     <= req_bad;
                    cnt     <= CNT_INIT;
                    wbuf    <= zext_store(bus.Funct3, bus.StoreData);
                end
                RD: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (a_store) begin
                        wbuf <= merged;
                    end else begin
                        load_q <= load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        bus.MemAddr = {a_addr[31:2], 2'b00};
        case (state)
            IDLE: begin
                bus.MemAddr = {bus.Addr[31:2], 2'b00};
                if (bus.Req) begin
                    if (req_bad)            state_next = RESP;
                    else if (req_direct_wr) state_next = WR;
                    else                    state_next = RD;
                end
            end
            RD:      if (cnt == 8'd0) state_next = a_store ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.MemWe        = (state == WR) && reset;
    assign bus.MemWriteData = wbuf;
    assign bus.LoadData     = load_q;
    assign bus.Ready        = (state == RESP);
    assign bus.MisalignExc  = (state == RESP) && err;
    assign bus.Busy         = (state != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a word RAM model
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.READ_LATENCY(1), .MMIO_HI(16'hFFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] ram [0:1023];
    logic [31:0] rd_q = '0;
    int          we_count = 0;
    logic        poke_en = 1'b0;
    logic [9:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;

    // Synchronous-read word memory; MMIO writes are counted but do not land in RAM.
    always @(posedge clk) begin
        if (poke_en) ram[poke_idx] <= poke_val;
        if (bus.MemWe) begin
            we_count <= we_count + 1;
            if (bus.MemAddr[31:16] != 16'hFFFF) ram[bus.MemAddr[11:2]] <= bus.MemWriteData;
        end
        rd_q <= ram[bus.MemAddr[11:2]];
    end
    assign bus.MemReadData = rd_q;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic poke(input logic [9:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issues one request in an IDLE cycle T; k counts cycles after T, sampled on the falling edge.
    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       output int rdy, output int wec, output int pulses,
                       output logic [31:0] wd, output logic ex, output logic busy1);
        rdy = -1; wec = -1; pulses = 0; wd = '0; ex = 1'b0; busy1 = 1'b0;
        @(negedge clk);
        bus.Req = 1'b1; bus.IsStore = st; bus.Funct3 = f3; bus.Addr = a; bus.StoreData = d;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.Req = 1'b0;
            if (k == 1) busy1 = bus.Busy;
            if (bus.MemWe) begin
                pulses++;
                if (wec < 0) begin
                    wec = k;
                    wd  = bus.MemWriteData;
                end
            end
            if (bus.Ready) begin
                rdy = k;
                ex  = bus.MisalignExc;
                break;
            end
        end
    endtask

    int          rdy, wec, pulses, wc0;
    logic [31:0] wd;
    logic        ex, busy1;

    initial begin
        bus.Req = 1'b0; bus.IsStore = 1'b0; bus.Funct3 = 3'b000; bus.Addr = '0; bus.StoreData = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.Ready), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_exc", 32'(bus.MisalignExc), 32'd0);
        check("rst_we", 32'(bus.MemWe), 32'd0);
        check("rst_loaddata", bus.LoadData, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        poke(10'd64, 32'h80FF7F01);
        poke(10'd63, 32'hDEADBEEF);
        poke(10'd128, 32'h55667788);

        run(1'b0, 3'b010, 32'h100, 32'h0, rdy, wec, pulses, wd, ex, busy1);
        check("lw_ready_cyc", 32'(rdy), 32'd2);
        check("lw_busy", 32'(busy1), 32'd1);
        check("lw_data", bus.LoadData, 32'h80FF7F01);
        check("lw_no_we", 32'(pulses), 32'd0);
        check("lw_exc", 32'(ex), 32'd0);

        run(1'b0, 3'b000, 32'h103, 32'h0, rdy, wec, pulses, wd, ex, busy1);
        check("lb_103", bus.LoadData, 32'hFFFFFF80);
        run(1'b0, 3'b100, 32'h103, 32'h0, rdy, wec, pulses, wd, ex, busy1);
        check("lbu_103", bus.LoadData, 32'h00000080);
        run(1'b0, 3'b001, 32'h102, 32'h0, rdy, wec, pulses, wd, ex, busy1);
        check("lh_102", bus.LoadData, 32'hFFFF80FF);
        run(1'b0, 3'b101, 32'h100, 32'h0, rdy, wec, pulses, wd, ex, busy1);
        check("lhu_100", bus.LoadData, 32'h00007F01);
        run(1'b0, 3'b000, 32'h101, 32'h0, rdy, wec, pulses, wd, ex, busy1);
        check("lb_101", bus.LoadData, 32'h0000007F);
        check("lb_101_no_we", 32'(pulses), 32'd0);

        poke(10'd64, 32'h11223344);
        run(1'b1, 3'b000, 32'h101, 32'hFFFFFFAB, rdy, wec, pulses, wd, ex, busy1);
        check("sb_we_cyc", 32'(wec), 32'd2);
        check("sb_wdata", wd, 32'h1122AB44);
        check("sb_ready_cyc", 32'(rdy), 32'd3);
        check("sb_pulses", 32'(pulses), 32'd1);
        check("sb_ram", ram[64], 32'h1122AB44);
        check("sb_loaddata_hold", bus.LoadData, 32'h0000007F);

        run(1'b1, 3'b001, 32'h0FC, 32'h00001234, rdy, wec, pulses, wd, ex, busy1);
        check("sh_0fc_wdata", wd, 32'hDEAD1234);
        check("sh_0fc_ready_cyc", 32'(rdy), 32'd3);
        check("sh_0fc_exc", 32'(ex), 32'd0);

        run(1'b1, 3'b001, 32'h0FD, 32'h00009999, rdy, wec, pulses, wd, ex, busy1);
        check("sh_mis_ready_cyc", 32'(rdy), 32'd1);
        check("sh_mis_exc", 32'(ex), 32'd1);
        check("sh_mis_no_we", 32'(pulses), 32'd0);
        check("sh_mis_ram", ram[63], 32'hDEAD1234);

        run(1'b0, 3'b010, 32'h102, 32'h0, rdy, wec, pulses, wd, ex, busy1);
        check("lw_mis_ready_cyc", 32'(rdy), 32'd1);
        check("lw_mis_exc", 32'(ex), 32'd1);
        check("lw_mis_loaddata_hold", bus.LoadData, 32'h0000007F);

        run(1'b0, 3'b011, 32'h100, 32'h0, rdy, wec, pulses, wd, ex, busy1);
        check("illegal_f3_exc", 32'(ex), 32'd1);
        check("illegal_f3_ready_cyc", 32'(rdy), 32'd1);

        run(1'b1, 3'b000, 32'hFFFF0004, 32'h1234565A, rdy, wec, pulses, wd, ex, busy1);
        check("mmio_sb_we_cyc", 32'(wec), 32'd1);
        check("mmio_sb_wdata", wd, 32'h0000005A);
        check("mmio_sb_ready_cyc", 32'(rdy), 32'd2);

        run(1'b1, 3'b010, 32'h108, 32'hCAFEF00D, rdy, wec, pulses, wd, ex, busy1);
        check("sw_we_cyc", 32'(wec), 32'd1);
        check("sw_ready_cyc", 32'(rdy), 32'd2);
        check("sw_ram", ram[66], 32'hCAFEF00D);

        @(negedge clk);
        wc0 = we_count;
        bus.Req = 1'b1; bus.IsStore = 1'b1; bus.Funct3 = 3'b001; bus.Addr = 32'h200; bus.StoreData = 32'h0000BEEF;
        @(negedge clk);
        bus.Req = 1'b0;
        @(negedge clk);
        check("rst_wr_we_before", 32'(bus.MemWe), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_wr_we_gated", 32'(bus.MemWe), 32'd0);
        @(negedge clk);
        check("rst_wr_busy", 32'(bus.Busy), 32'd0);
        check("rst_wr_ready", 32'(bus.Ready), 32'd0);
        check("rst_wr_loaddata", bus.LoadData, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wr_no_write", 32'(we_count - wc0), 32'd0);
        check("rst_wr_ram", ram[128], 32'h55667788);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
